ysyx_22050710_mem_arbiter: RTL



---
 rtl/ysyx_22050710_defs.sv | 29 ++
 rtl/ysyx_22050710_lsu_align.sv | 74 +++++++
 rtl/ysyx_22050710_mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_defs.sv
// Shared encodings for the ysyx_22050710 memory path: decoder MemOP codes,
// arbiter FSM states and requester owner IDs.
package ysyx_22050710_defs;

    // MemOP codes as produced by the decoder; bit[2:1] is log2(access bytes)
    typedef enum logic [2:0] {
        MEMOP_LB  = 3'b000,
        MEMOP_LBU = 3'b001,
        MEMOP_LH  = 3'b010,
        MEMOP_LHU = 3'b011,
        MEMOP_LW  = 3'b100,
        MEMOP_LWU = 3'b101,
        MEMOP_LD  = 3'b110,
        MEMOP_INV = 3'b111
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MREQ = 2'd1,
        ST_MRSP = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Combinational access shaping: byte strobes, store data lane shift,
// load data extraction/extension and the alignment/invalid-op check.
module ysyx_22050710_lsu_align
    import ysyx_22050710_defs::*;
(
    input  logic        is_ifu,
    input  logic [2:0]  offset,
    input  logic        wen,
    input  logic [2:0]  memop,
    input  logic [63:0] wdata,
    input  logic [63:0] mem_rdata,
    output logic [7:0]  wmask,
    output logic [63:0] mem_wdata,
    output logic [63:0] load_data,
    output logic        access_err
);
    logic [5:0]  bit_shift;
    logic [63:0] shifted;

    assign bit_shift = {offset, 3'b000};
    assign mem_wdata = wdata << bit_shift;
    assign shifted   = mem_rdata >> bit_shift;

    // Reject misaligned addresses and the invalid MemOP code
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        access_err = 1'b0;
        if (is_ifu) begin
            access_err = (offset[1:0] != 2'b00);
        end else begin
            unique case (memop_e'(memop))
                MEMOP_LB, MEMOP_LBU: access_err = 1'b0;
                MEMOP_LH, MEMOP_LHU: access_err = offset[0];
                MEMOP_LW, MEMOP_LWU: access_err = (offset[1:0] != 2'b00);
                MEMOP_LD:            access_err = (offset != 3'b000);
                default:             access_err = 1'b1;
            endcase
        end
    end

    // Byte strobes for stores only; loads and fetches never write
    always_comb begin
        wmask = 8'h00;
        if (wen && !is_ifu) begin
            unique case (memop_e'(memop))
                MEMOP_LB, MEMOP_LBU: wmask = 8'h01 << offset;
                MEMOP_LH, MEMOP_LHU: wmask = 8'h03 << offset;
                MEMOP_LW, MEMOP_LWU: wmask = 8'h0F << offset;
                MEMOP_LD:            wmask = 8'hFF;
                default:             wmask = 8'h00;
            endcase
        end
    end

    // Load data: lane-shifted then sign/zero extended; fetch picks a 32-bit word
    always_comb begin
        load_data = 64'h0;
        if (is_ifu) begin
            load_data = {32'h0, (offset[2] ? mem_rdata[63:32] : mem_rdata[31:0])};
        end else begin
            unique case (memop_e'(memop))
                MEMOP_LB:  load_data = {{56{shifted[7]}}, shifted[7:0]};
                MEMOP_LBU: load_data = {56'h0, shifted[7:0]};
                MEMOP_LH:  load_data = {{48{shifted[15]}}, shifted[15:0]};
                MEMOP_LHU: load_data = {48'h0, shifted[15:0]};
                MEMOP_LW:  load_data = {{32{shifted[31]}}, shifted[31:0]};
                MEMOP_LWU: load_data = {32'h0, shifted[31:0]};
                MEMOP_LD:  load_data = shifted;
                default:   load_data = 64'h0;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22050710_mem_arbiter.sv
// Single-port memory arbiter: round-robin grant between IFU and LSU, one
// outstanding memory transaction, response returned to the owner.
module ysyx_22050710_mem_arbiter
    import ysyx_22050710_defs::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req_valid,
    output logic                o_if_req_ready,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_rsp_valid,
    input  logic                i_if_rsp_ready,
    output logic [31:0]         o_if_rdata,
    output logic                o_if_rsp_err,
    input  logic                i_ls_req_valid,
    output logic                o_ls_req_ready,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic                i_ls_wen,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [2:0]          i_ls_memop,
    output logic                o_ls_rsp_valid,
    input  logic                i_ls_rsp_ready,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_ls_rsp_err,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_rsp_valid,
    output logic                o_mem_rsp_ready,
    input  logic [DATA_W-1:0]   i_mem_rdata
);
    state_e              state_q, state_d;
    owner_e              last_grant_q, owner_q, winner;
    logic [ADDR_W-1:0]   addr_q, cur_addr;
    logic                wen_q, cur_wen, err_q, grant, accept, idle, cur_is_ifu;
    logic [2:0]          memop_q, cur_memop;
    logic [DATA_W-1:0]   wdata_q, cur_wdata, rdata_q, mem_wdata, load_data;
    logic [7:0]          wmask;
    logic                access_err;

    // Round-robin pick: on contention the requester not granted last time wins
    always_comb begin
        grant  = i_if_req_valid | i_ls_req_valid;
        winner = OWNER_IFU;
        if (i_if_req_valid && i_ls_req_valid)
            winner = (last_grant_q == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
        else if (i_ls_req_valid)
            winner = OWNER_LSU;
    end

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && grant;

    // The single aligner sees the incoming request in IDLE, the held one afterwards
    assign cur_is_ifu = idle ? (winner == OWNER_IFU) : (owner_q == OWNER_IFU);
    assign cur_addr   = (idle && winner == OWNER_IFU) ? i_if_addr
                      : (idle ? i_ls_addr : addr_q);
    assign cur_wen    = idle ? ((winner == OWNER_LSU) && i_ls_wen) : wen_q;
    assign cur_memop  = idle ? i_ls_memop : memop_q;
    assign cur_wdata  = idle ? i_ls_wdata : wdata_q;

    ysyx_22050710_lsu_align u_align (
        .is_ifu     (cur_is_ifu),
        .offset     (cur_addr[2:0]),
        .wen        (cur_wen),
        .memop      (cur_memop),
        .wdata      (cur_wdata),
        .mem_rdata  (i_mem_rdata),
        .wmask      (wmask),
        .mem_wdata  (mem_wdata),
        .load_data  (load_data),
        .access_err (access_err)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and all outputs; outputs are zero outside their owning state
    always_comb begin
        state_d         = state_q;
        o_if_req_ready  = 1'b0;
        o_ls_req_ready  = 1'b0;
        o_if_rsp_valid  = 1'b0;
        o_if_rdata      = 32'h0;
        o_if_rsp_err    = 1'b0;
        o_ls_rsp_valid  = 1'b0;
        o_ls_rdata      = '0;
        o_ls_rsp_err    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_addr      = '0;
        o_mem_wen       = 1'b0;
        o_mem_wdata     = '0;
        o_mem_wmask     = '0;
        o_mem_rsp_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_if_req_ready = grant && (winner == OWNER_IFU);
                o_ls_req_ready = grant && (winner == OWNER_LSU);
                if (grant) state_d = access_err ? ST_RESP : ST_MREQ;
            end
            ST_MREQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
                o_mem_wen       = wen_q;
                o_mem_wdata     = mem_wdata;
                o_mem_wmask     = wmask;
                if (i_mem_req_ready) state_d = ST_MRSP;
            end
            ST_MRSP: begin
                o_mem_rsp_ready = 1'b1;
                if (i_mem_rsp_valid) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q == OWNER_IFU) begin
                    o_if_rsp_valid = 1'b1;
                    o_if_rdata     = rdata_q[31:0];
                    o_if_rsp_err   = err_q;
                    if (i_if_rsp_ready) state_d = ST_IDLE;
                end else begin
                    o_ls_rsp_valid = 1'b1;
                    o_ls_rdata     = rdata_q;
                    o_ls_rsp_err   = err_q;
                    if (i_ls_rsp_ready) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture at accept, processed response capture in MRSP
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: these few datapath registers are reset because they feed outputs that must read 0 after reset.
        if (!i_rst_n) begin
            last_grant_q <= OWNER_IFU;
            owner_q      <= OWNER_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            memop_q      <= 3'b000;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else if (accept) begin
            last_grant_q <= winner;
            owner_q      <= winner;
            addr_q       <= cur_addr;
            wen_q        <= cur_wen;
            memop_q      <= i_ls_memop;
            wdata_q      <= (winner == OWNER_LSU) ? i_ls_wdata : '0;
            err_q        <= access_err;
            rdata_q      <= '0;
        end else if (state_q == ST_MRSP && i_mem_rsp_valid) begin
            rdata_q      <= wen_q ? '0 : load_data;
        end
    end

endmodule
